imem_ctrl: RTL

Scheduler for the single-port instruction memory that sits between the fetch stage and its `memory_md` instance. It arbitrates each memory cycle between two requesters: instruction fetch reads and program-loader writes. It drives the memory port and returns grant/valid handshakes to both. It enforces a fetch-starvation bound on the loader and, optionally, a boot phase that keeps fetch off the memory until a program image is loaded.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_starve_cnt.sv | 37 +++
 rtl/imem_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the instruction-memory scheduler.
//   IMEM_BOOT / IMEM_RUN   : scheduler state encoding
//   IMEM_AW                : default word-address width of the memory port
//   IMEM_MAX_FETCH_RUN     : default contested-fetch run length before the loader wins
//   IMEM_ADDR_LSB          : lowest byte-address bit that reaches the memory port
//   IMEM_CNT_W             : width of the fetch-run counter
package imem_pkg;

    typedef logic [0:0] imem_state_t;

    localparam imem_state_t IMEM_BOOT = 1'b0;
    localparam imem_state_t IMEM_RUN  = 1'b1;

    localparam int unsigned IMEM_AW            = 16;
    localparam int unsigned IMEM_MAX_FETCH_RUN = 8;
    localparam int unsigned IMEM_ADDR_LSB      = 2;
    localparam int unsigned IMEM_CNT_W         = 8;

endpackage

// File: rtl/imem_starve_cnt.sv
// imem_starve_cnt: saturating count of consecutive contested fetch grants.
// Ports:
//   clk      in  : clock
//   rst_n    in  : synchronous reset, active HIGH despite the name
//   i_inc    in  : a contested fetch grant happened this cycle
//   i_clr    in  : loader idle or loader granted this cycle (wins over i_inc)
//   o_at_max out : count has reached MAX, loader must win the next contest
module imem_starve_cnt
    import imem_pkg::*;
#(
    parameter int unsigned MAX = IMEM_MAX_FETCH_RUN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    logic [IMEM_CNT_W-1:0] r_cnt;
    logic                  w_at_max;

    assign w_at_max = (r_cnt == IMEM_CNT_W'(MAX));
    assign o_at_max = w_at_max;

    // Count contested fetch wins, holding at MAX until cleared.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + IMEM_CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: per-cycle scheduler for the single-port instruction memory,
// arbitrating fetch reads against program-loader writes.
// Optional boot phase enabled by defining IMEM_CTRL_BOOT_EN: fetch is held
// off the memory until the loader signals ld_done.
// Ports:
//   clk, rst_n                 : clock; synchronous reset, active HIGH
//   if_req, if_addr            : fetch read request and byte address
//   if_gnt                     : fetch read issued this cycle (combinational)
//   if_rvalid                  : read data for last cycle's grant is valid
//   ld_valid, ld_addr, ld_wdata: loader write request
//   ld_ready                   : loader write accepted this cycle (combinational)
//   ld_done                    : loader image complete (boot feature only)
//   ld_err                     : accepted loader write was misaligned
//   mem_ren/wen/addr/wdata     : memory port, combinational from the grant
//   boot_done                  : fetch is permitted
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned AW            = IMEM_AW,
    parameter int unsigned MAX_FETCH_RUN = IMEM_MAX_FETCH_RUN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    input  logic          ld_done,
    output logic          ld_err,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          boot_done
);

    logic w_in_boot;
    logic w_if_gnt;
    logic w_ld_gnt;
    logic w_ld_aligned;
    logic w_cnt_inc;
    logic w_cnt_clr;
    logic w_at_max;
    logic r_if_rvalid;

`ifdef IMEM_CTRL_BOOT_EN
    imem_state_t r_state;
    imem_state_t w_state_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IMEM_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave BOOT only once no write is pending, so a final write issued
    // alongside ld_done still lands before fetch is let in.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IMEM_BOOT && ld_done && !ld_valid) begin
            w_state_nxt = IMEM_RUN;
        end
    end

    assign w_in_boot = (r_state == IMEM_BOOT);

    logic w_unused;
    assign w_unused = ^{if_addr[31:AW+IMEM_ADDR_LSB], if_addr[IMEM_ADDR_LSB-1:0],
                        ld_addr[31:AW+IMEM_ADDR_LSB]};
`else
    assign w_in_boot = 1'b0;

    logic w_unused;
    assign w_unused = ^{if_addr[31:AW+IMEM_ADDR_LSB], if_addr[IMEM_ADDR_LSB-1:0],
                        ld_addr[31:AW+IMEM_ADDR_LSB], ld_done};
`endif

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        w_if_gnt  = 1'b0;
        w_ld_gnt  = 1'b0;
        w_cnt_inc = 1'b0;
        if (!rst_n) begin
            if (w_in_boot) begin
                w_ld_gnt = ld_valid;
            end else if (ld_valid && (!if_req || w_at_max)) begin
                w_ld_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt  = 1'b1;
                w_cnt_inc = ld_valid;
            end
        end
    end

    assign w_cnt_clr = !ld_valid || w_ld_gnt;

    imem_starve_cnt #(
        .MAX (MAX_FETCH_RUN)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_cnt_inc),
        .i_clr    (w_cnt_clr),
        .o_at_max (w_at_max)
    );

    // Read data returns one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_if_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
        end
    end

    assign w_ld_aligned = (ld_addr[IMEM_ADDR_LSB-1:0] == '0);

    // Memory port driven straight from this cycle's grant.
    always_comb begin
        mem_ren   = w_if_gnt;
        mem_wen   = w_ld_gnt && w_ld_aligned;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_addr = if_addr[IMEM_ADDR_LSB +: AW];
        end else if (w_ld_gnt) begin
            mem_addr  = ld_addr[IMEM_ADDR_LSB +: AW];
            mem_wdata = ld_wdata;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ld_ready  = w_ld_gnt;
    assign ld_err    = w_ld_gnt && !w_ld_aligned;
    // Masked during reset so a grant from the cycle before reset is not reported.
    assign if_rvalid = r_if_rvalid && !rst_n;
    assign boot_done = !rst_n && !w_in_boot;

endmodule
